// File: rtl/capture_buffer.sv
// capture_buffer: arms on a WriteStrobe rising edge, stores a capture in RAM, streams it out MSB-beat first.
// Optional input decimation is enabled by defining CAPTURE_DECIMATE_EN (adds the DecimateRatio port).

module capture_buffer #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter int DEPTH     = 1024,
  parameter int LEN_W     = 11
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [IN_WIDTH-1:0]  DataIn,
  input  logic                 DataInValid,
  input  logic                 WriteStrobe,
  input  logic [LEN_W-1:0]     CaptureLength,
  input  logic                 Abort,
  input  logic                 ReadEnable,
`ifdef CAPTURE_DECIMATE_EN
  input  logic [7:0]           DecimateRatio,
`endif
  output logic [OUT_WIDTH-1:0] DataOut,
  output logic                 DataValid,
  output logic                 DataReadyToSend,
  output logic                 FifoNotFull,
  output logic [LEN_W-1:0]     WordsStored
);

  localparam int BEATS = IN_WIDTH / OUT_WIDTH;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [LEN_W-1:0] DEPTH_L   = LEN_W'(DEPTH);
  localparam logic [BW-1:0]    LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {
    READY_TO_STORE = 2'b00,
    STORING        = 2'b01,
    SENDING        = 2'b10
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           strobe_q, strobe_d;
  logic                 arm_block_q, arm_block_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     words_q, words_d;
  logic [LEN_W-1:0]     rptr_q, rptr_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [OUT_WIDTH-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic [IN_WIDTH-1:0]  rd_word_q, rd_word_d;
`ifdef CAPTURE_DECIMATE_EN
  logic [7:0]           ratio_q, ratio_d;
  logic [7:0]           phase_q, phase_d;
`endif

  logic [IN_WIDTH-1:0]  mem [DEPTH];
  logic                 wr_en;
  logic                 accept;
  logic                 strobe_edge;
  logic                 keep;
  logic [AW-1:0]        wr_addr;
  logic [AW-1:0]        rd_addr;
  logic [IN_WIDTH-1:0]  shifted;
  logic [LEN_W-1:0]     len_eff;

  always_comb begin
    state_d      = state_q;
    strobe_d     = {strobe_q[0], WriteStrobe};
    arm_block_d  = arm_block_q & WriteStrobe;
    len_d        = len_q;
    words_d      = words_q;
    rptr_d       = rptr_q;
    beat_d       = beat_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    wr_en        = 1'b0;
    keep         = 1'b1;
`ifdef CAPTURE_DECIMATE_EN
    ratio_d      = ratio_q;
    phase_d      = phase_q;
    keep         = (phase_q == 8'd0);
`endif
    // A strobe still high when reset releases must drop before it can arm.
    strobe_edge  = (strobe_q == 2'b01) && !arm_block_q;
    accept       = ReadEnable && (state_q == SENDING) && !Abort;
    len_eff      = ((CaptureLength == '0) || (CaptureLength > DEPTH_L)) ? DEPTH_L : CaptureLength;
    shifted      = rd_word_q << (beat_q * OUT_WIDTH);

    case (state_q)
      READY_TO_STORE: begin
        if (strobe_edge) begin
          state_d = STORING;
          len_d   = len_eff;
          words_d = '0;
          rptr_d  = '0;
          beat_d  = '0;
`ifdef CAPTURE_DECIMATE_EN
          ratio_d = (DecimateRatio == 8'd0) ? 8'd1 : DecimateRatio;
          phase_d = 8'd0;
`endif
        end
      end
      STORING: begin
        if (DataInValid) begin
`ifdef CAPTURE_DECIMATE_EN
          phase_d = ((phase_q + 8'd1) == ratio_q) ? 8'd0 : phase_q + 8'd1;
`endif
          if (keep && (words_q < len_q)) begin
            wr_en   = 1'b1;
            words_d = words_q + 1'b1;
            if (words_d == len_q) state_d = SENDING;
          end
        end
      end
      SENDING: begin
        if (accept) begin
          data_valid_d = 1'b1;
          data_out_d   = shifted[IN_WIDTH-1 -: OUT_WIDTH];
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            if ((rptr_q + 1'b1) == len_q) begin
              state_d = READY_TO_STORE;
              rptr_d  = '0;
            end else begin
              rptr_d = rptr_q + 1'b1;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = READY_TO_STORE;
    endcase

    if (Abort) begin
      state_d      = READY_TO_STORE;
      words_d      = '0;
      rptr_d       = '0;
      beat_d       = '0;
      data_valid_d = 1'b0;
      wr_en        = 1'b0;
`ifdef CAPTURE_DECIMATE_EN
      phase_d      = 8'd0;
`endif
    end

    // Prefetch the word at the next read pointer, forwarding a same-cycle write.
    wr_addr   = words_q[AW-1:0];
    rd_addr   = rptr_d[AW-1:0];
    rd_word_d = (wr_en && (wr_addr == rd_addr)) ? DataIn : mem[rd_addr];
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= READY_TO_STORE;
      strobe_q     <= 2'b00;
      arm_block_q  <= 1'b1;
      len_q        <= '0;
      words_q      <= '0;
      rptr_q       <= '0;
      beat_q       <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      rd_word_q    <= '0;
`ifdef CAPTURE_DECIMATE_EN
      ratio_q      <= 8'd1;
      phase_q      <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      strobe_q     <= strobe_d;
      arm_block_q  <= arm_block_d;
      len_q        <= len_d;
      words_q      <= words_d;
      rptr_q       <= rptr_d;
      beat_q       <= beat_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      rd_word_q    <= rd_word_d;
`ifdef CAPTURE_DECIMATE_EN
      ratio_q      <= ratio_d;
      phase_q      <= phase_d;
`endif
    end
  end

  always_ff @(posedge Clock) begin
    if (wr_en) mem[wr_addr] <= DataIn;
  end

  assign DataOut         = data_out_q;
  assign DataValid       = data_valid_q;
  assign DataReadyToSend = (state_q == SENDING);
  assign FifoNotFull     = (state_q == READY_TO_STORE) || (state_q == STORING);
  assign WordsStored     = words_q;

endmodule

// File: tb/tb_capture_buffer.sv
// tb_capture_buffer: randomized capture/readout scenarios checked against a queue-based beat model.
// Define CAPTURE_DECIMATE_EN to also exercise the decimation port.

module tb_capture_buffer;

  localparam int IN_W  = 32;
  localparam int OUT_W = 8;
  localparam int DEPTH = 1024;
  localparam int LEN_W = 11;
  localparam int BEATS = IN_W / OUT_W;

  logic              Clock = 1'b0;
  logic              Reset;
  logic [IN_W-1:0]   DataIn;
  logic              DataInValid;
  logic              WriteStrobe;
  logic [LEN_W-1:0]  CaptureLength;
  logic              Abort;
  logic              ReadEnable;
`ifdef CAPTURE_DECIMATE_EN
  logic [7:0]        DecimateRatio;
`endif
  logic [OUT_W-1:0]  DataOut;
  logic              DataValid;
  logic              DataReadyToSend;
  logic              FifoNotFull;
  logic [LEN_W-1:0]  WordsStored;

  capture_buffer #(
    .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .DEPTH(DEPTH), .LEN_W(LEN_W)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .DataIn(DataIn),
    .DataInValid(DataInValid),
    .WriteStrobe(WriteStrobe),
    .CaptureLength(CaptureLength),
    .Abort(Abort),
    .ReadEnable(ReadEnable),
`ifdef CAPTURE_DECIMATE_EN
    .DecimateRatio(DecimateRatio),
`endif
    .DataOut(DataOut),
    .DataValid(DataValid),
    .DataReadyToSend(DataReadyToSend),
    .FifoNotFull(FifoNotFull),
    .WordsStored(WordsStored)
  );

  always #5 Clock = ~Clock;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] src_words[$];
  logic [31:0] exp_words[$];
  logic [7:0]  exp_beats[$];
  logic [7:0]  got_beats[$];
  int          ro_timing_err;
  bit          ro_timeout;

  function automatic int eff_len(input int len);
    return ((len == 0) || (len > DEPTH)) ? DEPTH : len;
  endfunction

  // Model: every stored word becomes BEATS beats, most-significant first.
  function automatic void build_expected();
    exp_beats.delete();
    foreach (exp_words[i])
      for (int b = 0; b < BEATS; b++)
        exp_beats.push_back(8'((exp_words[i] >> (IN_W - OUT_W * (b + 1))) & 32'hFF));
  endfunction

  function automatic int first_diff();
    int n = (got_beats.size() < exp_beats.size()) ? got_beats.size() : exp_beats.size();
    for (int i = 0; i < n; i++)
      if (got_beats[i] !== exp_beats[i]) return i;
    if (got_beats.size() != exp_beats.size()) return n;
    return -1;
  endfunction

  task automatic arm(input int len);
    CaptureLength = LEN_W'(len);
    WriteStrobe   = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    WriteStrobe   = 1'b0;
  endtask

  // src: 0 random, 1 running index of valid words, 2 taken from src_words.
  task automatic feed(input int len, input int ratio, input int valid_pct, input int src, input int extra);
    int need = eff_len(len);
    int vidx = 0;
    int cyc  = 0;
    exp_words.delete();
    while ((exp_words.size() < need) && (cyc < need * ratio * 10 + 100)) begin
      DataInValid = ($urandom_range(1, 100) <= valid_pct);
      case (src)
        0:       DataIn = $urandom;
        1:       DataIn = 32'(vidx);
        default: DataIn = src_words[vidx % src_words.size()];
      endcase
      if (DataInValid) begin
        if ((vidx % ratio) == 0) exp_words.push_back(DataIn);
        vidx++;
      end
      @(negedge Clock);
      cyc++;
    end
    for (int i = 0; i < extra; i++) begin
      DataInValid = 1'b1;
      DataIn      = $urandom;
      @(negedge Clock);
    end
    DataInValid = 1'b0;
  endtask

  // mode: 0 ReadEnable held high, 1 toggling, 2 random.
  task automatic run_readout(input int mode, input int max_cyc);
    logic acc = 1'b0;
    got_beats.delete();
    ro_timing_err = 0;
    ro_timeout    = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      if (DataValid !== acc) ro_timing_err++;
      if (DataValid === 1'b1) got_beats.push_back(DataOut);
      if ((DataReadyToSend !== 1'b1) && (c > 0)) begin
        ro_timeout = 1'b0;
        break;
      end
      case (mode)
        0:       ReadEnable = 1'b1;
        1:       ReadEnable = ((c % 2) == 0);
        default: ReadEnable = 1'($urandom_range(0, 1));
      endcase
      acc = ReadEnable && (DataReadyToSend === 1'b1);
      @(negedge Clock);
    end
    ReadEnable = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; WriteStrobe = 1'b0; DataInValid = 1'b1; ReadEnable = 1'b1; Abort = 1'b1;
    DataIn = $urandom;
    repeat (3) @(negedge Clock);
    tests_run++;
    if ({DataOut, DataValid, DataReadyToSend, FifoNotFull, WordsStored} !== {8'h00, 1'b0, 1'b0, 1'b1, 11'd0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_reset: got out=%0h dv=%0b drts=%0b fnf=%0b ws=%0d expected 0 0 0 1 0",
               DataOut, DataValid, DataReadyToSend, FifoNotFull, WordsStored);
    end
    Reset = 1'b0; DataInValid = 1'b0; ReadEnable = 1'b0; Abort = 1'b0;
    @(negedge Clock);
    tests_run++;
    if ({DataOut, DataValid, DataReadyToSend, FifoNotFull, WordsStored} !== {8'h00, 1'b0, 1'b0, 1'b1, 11'd0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_after_release: got out=%0h dv=%0b drts=%0b fnf=%0b ws=%0d expected 0 0 0 1 0",
               DataOut, DataValid, DataReadyToSend, FifoNotFull, WordsStored);
    end
  endtask

  task automatic test_basic_capture();
    int d;
    src_words = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF5A};
    arm(4);
    feed(4, 1, 100, 2, 0);
    tests_run++;
    if ({WordsStored, DataReadyToSend, FifoNotFull} !== {11'd4, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL basic_stored: got ws=%0d drts=%0b fnf=%0b expected 4 1 0", WordsStored, DataReadyToSend, FifoNotFull);
    end
    build_expected();
    run_readout(0, 100);
    tests_run++;
    if (ro_timeout || (ro_timing_err != 0)) begin
      tests_failed++;
      $display("[TB] FAIL basic_timing: got timeout=%0b timing_err=%0d expected 0 0", ro_timeout, ro_timing_err);
    end
    d = first_diff();
    tests_run++;
    if (d != -1) begin
      tests_failed++;
      $display("[TB] FAIL basic_stream: got first diff at beat %0d (%0d beats) expected none (16 beats)", d, got_beats.size());
    end
    tests_run++;
    if ({FifoNotFull, DataReadyToSend} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL basic_back_to_ready: got fnf=%0b drts=%0b expected 1 0", FifoNotFull, DataReadyToSend);
    end
    repeat (2) @(negedge Clock);
    tests_run++;
    if ({DataValid, DataOut} !== {1'b0, 8'h5A}) begin
      tests_failed++;
      $display("[TB] FAIL basic_hold: got dv=%0b out=%0h expected 0 5a", DataValid, DataOut);
    end
  endtask

  task automatic test_readenable_patterns();
    logic [7:0] got_a[$];
    int len = $urandom_range(1, 24);
    int dv_count = 0;
    int d_a, d_b;
    src_words.delete();
    for (int i = 0; i < 24; i++) src_words.push_back($urandom);
    arm(len);
    feed(len, 1, 100, 2, 0);
    build_expected();
    run_readout(0, 200);
    d_a = first_diff();
    got_a = got_beats;
    arm(len);
    feed(len, 1, 60, 2, 0);
    run_readout(1, 400);
    d_b = first_diff();
    tests_run++;
    if ((d_a != -1) || (d_b != -1)) begin
      tests_failed++;
      $display("[TB] FAIL re_streams: got diff held=%0d toggled=%0d expected -1 -1 (len %0d)", d_a, d_b, len);
    end
    tests_run++;
    if (got_a != got_beats) begin
      tests_failed++;
      $display("[TB] FAIL re_identical: got %0d vs %0d beats differing expected identical", got_a.size(), got_beats.size());
    end
    tests_run++;
    if (ro_timeout || (ro_timing_err != 0)) begin
      tests_failed++;
      $display("[TB] FAIL re_toggle_timing: got timeout=%0b timing_err=%0d expected 0 0", ro_timeout, ro_timing_err);
    end
    ReadEnable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      if (DataValid !== 1'b0) dv_count++;
    end
    ReadEnable = 1'b0;
    tests_run++;
    if (dv_count != 0) begin
      tests_failed++;
      $display("[TB] FAIL re_idle: got %0d DataValid cycles expected 0", dv_count);
    end
  endtask

  task automatic test_full_depth();
    int lens[2] = '{0, 1500};
    logic [7:0] lastb;
    int d;
    foreach (lens[k]) begin
      arm(lens[k]);
      feed(lens[k], 1, 75, 0, 6);
      tests_run++;
      if (WordsStored !== 11'(DEPTH)) begin
        tests_failed++;
        $display("[TB] FAIL full_words_%0d: got %0d expected %0d", lens[k], WordsStored, DEPTH);
      end
      build_expected();
      run_readout((k == 0) ? 2 : 0, DEPTH * BEATS * 4 + 50);
      d = first_diff();
      tests_run++;
      if (ro_timeout || (ro_timing_err != 0) || (d != -1)) begin
        tests_failed++;
        $display("[TB] FAIL full_stream_%0d: got timeout=%0b timing_err=%0d diff=%0d beats=%0d expected 0 0 -1 %0d",
                 lens[k], ro_timeout, ro_timing_err, d, got_beats.size(), DEPTH * BEATS);
      end
      lastb = (got_beats.size() == DEPTH * BEATS) ? got_beats[DEPTH * BEATS - 1] : 8'hxx;
      tests_run++;
      if (lastb !== exp_words[DEPTH-1][7:0]) begin
        tests_failed++;
        $display("[TB] FAIL full_last_beat_%0d: got %0h expected %0h", lens[k], lastb, exp_words[DEPTH-1][7:0]);
      end
    end
  endtask

  task automatic test_abort();
    int d;
    arm(8);
    DataInValid = 1'b1;
    repeat (3) begin
      DataIn = $urandom;
      @(negedge Clock);
    end
    DataInValid = 1'b0;
    tests_run++;
    if (WordsStored !== 11'd3) begin
      tests_failed++;
      $display("[TB] FAIL abort_pre_store: got %0d expected 3", WordsStored);
    end
    Abort = 1'b1;
    @(negedge Clock);
    Abort = 1'b0;
    tests_run++;
    if ({WordsStored, FifoNotFull} !== {11'd0, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL abort_storing: got ws=%0d fnf=%0b expected 0 1", WordsStored, FifoNotFull);
    end
    DataInValid = 1'b1;
    repeat (2) @(negedge Clock);
    DataInValid = 1'b0;
    tests_run++;
    if (WordsStored !== 11'd0) begin
      tests_failed++;
      $display("[TB] FAIL abort_not_storing: got %0d expected 0", WordsStored);
    end
    arm(4);
    feed(4, 1, 100, 0, 0);
    ReadEnable = 1'b1;
    repeat (5) @(negedge Clock);
    Abort = 1'b1;
    @(negedge Clock);
    Abort = 1'b0;
    ReadEnable = 1'b0;
    tests_run++;
    if ({DataValid, DataReadyToSend, WordsStored, FifoNotFull} !== {1'b0, 1'b0, 11'd0, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL abort_sending: got dv=%0b drts=%0b ws=%0d fnf=%0b expected 0 0 0 1",
               DataValid, DataReadyToSend, WordsStored, FifoNotFull);
    end
    CaptureLength = 11'd4;
    WriteStrobe = 1'b1;
    @(negedge Clock);
    Abort = 1'b1;
    @(negedge Clock);
    Abort = 1'b0;
    WriteStrobe = 1'b0;
    DataInValid = 1'b1;
    repeat (3) @(negedge Clock);
    DataInValid = 1'b0;
    tests_run++;
    if (WordsStored !== 11'd0) begin
      tests_failed++;
      $display("[TB] FAIL abort_vs_edge: got ws=%0d expected 0", WordsStored);
    end
    arm(3);
    feed(3, 1, 80, 0, 0);
    build_expected();
    run_readout(1, 100);
    d = first_diff();
    tests_run++;
    if (ro_timeout || (d != -1)) begin
      tests_failed++;
      $display("[TB] FAIL abort_recapture: got timeout=%0b diff=%0d expected 0 -1", ro_timeout, d);
    end
  endtask

  task automatic test_random_captures();
    int len, d;
    for (int it = 0; it < 4; it++) begin
      len = $urandom_range(1, 40);
      arm(len);
      feed(len, 1, $urandom_range(40, 100), 0, $urandom_range(0, 3));
      tests_run++;
      if (WordsStored !== 11'(len)) begin
        tests_failed++;
        $display("[TB] FAIL rand_words_%0d: got %0d expected %0d", it, WordsStored, len);
      end
      build_expected();
      run_readout($urandom_range(0, 2), len * BEATS * 4 + 20);
      d = first_diff();
      tests_run++;
      if (ro_timeout || (ro_timing_err != 0) || (d != -1)) begin
        tests_failed++;
        $display("[TB] FAIL rand_stream_%0d: got timeout=%0b timing_err=%0d diff=%0d expected 0 0 -1",
                 it, ro_timeout, ro_timing_err, d);
      end
    end
  endtask

  task automatic test_reset_strobe_held();
    int d;
    arm(5);
    DataInValid = 1'b1;
    repeat (2) begin
      DataIn = $urandom;
      @(negedge Clock);
    end
    WriteStrobe = 1'b1;
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    repeat (4) begin
      DataIn = $urandom;
      @(negedge Clock);
    end
    DataInValid = 1'b0;
    tests_run++;
    if ({WordsStored, FifoNotFull, DataReadyToSend, DataValid} !== {11'd0, 1'b1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL strobe_held_reset: got ws=%0d fnf=%0b drts=%0b dv=%0b expected 0 1 0 0",
               WordsStored, FifoNotFull, DataReadyToSend, DataValid);
    end
    WriteStrobe = 1'b0;
    @(negedge Clock);
    arm(2);
    feed(2, 1, 100, 0, 0);
    tests_run++;
    if (WordsStored !== 11'd2) begin
      tests_failed++;
      $display("[TB] FAIL strobe_rearm: got ws=%0d expected 2", WordsStored);
    end
    build_expected();
    run_readout(2, 80);
    d = first_diff();
    tests_run++;
    if (ro_timeout || (d != -1)) begin
      tests_failed++;
      $display("[TB] FAIL strobe_rearm_stream: got timeout=%0b diff=%0d expected 0 -1", ro_timeout, d);
    end
  endtask

`ifdef CAPTURE_DECIMATE_EN
  task automatic test_decimate();
    int d;
    DecimateRatio = 8'd3;
    arm(3);
    feed(3, 3, 100, 1, 0);
    build_expected();
    run_readout(0, 60);
    d = first_diff();
    tests_run++;
    if (ro_timeout || (d != -1)) begin
      tests_failed++;
      $display("[TB] FAIL decimate_3: got timeout=%0b diff=%0d expected 0 -1", ro_timeout, d);
    end
    DecimateRatio = 8'd0;
    arm(5);
    feed(5, 1, 70, 0, 0);
    build_expected();
    run_readout(2, 100);
    d = first_diff();
    tests_run++;
    if (ro_timeout || (d != -1)) begin
      tests_failed++;
      $display("[TB] FAIL decimate_0: got timeout=%0b diff=%0d expected 0 -1", ro_timeout, d);
    end
    DecimateRatio = 8'd1;
  endtask
`endif

  initial begin
    Reset = 1'b1; WriteStrobe = 1'b0; DataInValid = 1'b0; DataIn = '0;
    CaptureLength = '0; Abort = 1'b0; ReadEnable = 1'b0;
`ifdef CAPTURE_DECIMATE_EN
    DecimateRatio = 8'd1;
`endif
    test_reset();
    test_basic_capture();
    test_readenable_patterns();
    test_full_depth();
    test_abort();
    test_random_captures();
    test_reset_strobe_held();
`ifdef CAPTURE_DECIMATE_EN
    test_decimate();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
